integrate_dump_accumulator: RTL
===============================

Name: integrate_dump_accumulator

Overview:
Parametrised integrate-and-dump accumulator for the streaming datapath. It sums a programmable number of signed samples per window, then emits one result and restarts from zero. Accumulation is selectable between wrap and saturate. The input side has ready backpressure and the output side a valid/ready handshake with a one-entry holding register, for use between decimating stages.

Parameters:
I_BW, 5, input sample width (signed)
O_BW, 12, accumulator/output width (signed); O_BW >= I_BW
CNT_BW, 8, width of window-length control
SHIFT, 0, output right-shift amount; used only when ROUND_SHIFT_EN defined; 0 <= SHIFT < O_BW

Ports:
clk_i  input  1  clock, rising edge
rst_n_i  input  1  asynchronous active-low reset
en_i  input  1  enable; low = synchronous flush
dump_len_i  input  CNT_BW  samples per window; 0 treated as 1
sat_i  input  1  1 = saturating accumulate, 0 = wrap
data_i  input  I_BW  signed input sample
valid_i  input  1  input sample valid
ready_o  output  1  input can accept sample
data_o  output  O_BW  signed window sum
sat_o  output  1  saturation occurred in window of data_o
valid_o  output  1  output valid
ready_i  input  1  downstream accepts output

Behaviour:
- Reset (async, rst_n_i=0): acc, cnt, len_q, win_sat, data_o, sat_o, valid_o all 0.
- Accept = valid_i & ready_o.
- ready_o = en_i & ~(valid_o & ~ready_i & last), where last = (cnt == len_q_eff-1). It is combinational from ready_i.
- Window start (cnt==0, accepting): len_q <= max(dump_len_i,1). Within that same cycle, last is evaluated with this new length. dump_len_i changes mid-window are ignored.
- Sum: sext(acc) + sext(data_i) in O_BW+1 bits.
  - sat_i=1 with overflow: clamp to 2^(O_BW-1)-1 or -2^(O_BW-1), and set win_sat.
  - sat_i=0: wrap modulo 2^O_BW.
- Accept, not last: acc <= sum, cnt <= cnt+1.
- Accept, last:
  - data_o <= sum (including current sample), sat_o <= win_sat | this-cycle overflow, valid_o <= 1.
  - acc, cnt, win_sat <= 0.
  - Latency: result visible the cycle after the last sample.
- Back-to-back windows run with no bubble while ready_i=1.
- Output handshake:
  - valid_o=1 holds data_o/sat_o stable until valid_o & ready_i.
  - Transfer with no new completion: valid_o <= 0.
  - Transfer and completion in the same cycle: register reloads, valid_o stays 1.
- en_i=0 (sync flush): acc, cnt, win_sat, valid_o <= 0; ready_o=0. A pending output is dropped. The next window starts fresh when en_i returns high.
- valid_i=0: state held.
- Reset mid-window discards all state immediately.

Optional Feature:
Macro INTEGRATE_DUMP_ROUND_SHIFT_EN.
- Defined: output = (sum + 2^(SHIFT-1)) >>> SHIFT (round half up, arithmetic), computed in O_BW+1 bits and saturated to O_BW. SHIFT=0 is a passthrough. Adds no latency.
- Undefined: SHIFT is ignored and data_o is the raw window sum.

Test Plan:
1. Reset, en=1, len=4, sat=0, ready_i=1, samples 1,2,3,4 on consecutive cycles -> valid_o one cycle after 4th sample, data_o=10, sat_o=0; next 4 samples -2 each -> data_o=-8 with no bubble.
2. I_BW=5, O_BW=8, len=10, data=15 each. sat=1 -> data_o=127, sat_o=1. Repeat with sat=0 -> data_o=-106 (150 mod 256), sat_o=0.
3. len=2, ready_i=0, samples 3,4,5,6 -> first output 7 held. ready_o drops while sample 6 is pending. Raise ready_i -> 7 transfers, 6 accepted same cycle, next cycle data_o=11, valid_o=1.
4. dump_len_i=0, samples 5,-3,9 -> three outputs 5,-3,9, one per sample. Change dump_len_i mid-window of len=3 -> current window still closes after 3 samples.
5. en_i low after 2 of 4 samples while an output is pending -> valid_o=0, ready_o=0. Re-enable, samples 1,1,1,1 -> data_o=4. Assert rst_n_i low mid-window -> all outputs 0 immediately.
6. With INTEGRATE_DUMP_ROUND_SHIFT_EN, SHIFT=2: window sum 10 -> data_o=3; sum -10 -> data_o=-2; sum 2^(O_BW-1)-1 -> no overflow, data_o=2^(O_BW-3).

Source files
------------

// File: rtl/integrate_dump_accumulator.sv
// integrate_dump_accumulator
//   Sums a programmable number of signed samples per window, emits one window
//   result through a one-entry valid/ready output register, then restarts from
//   zero. Accumulation either wraps or saturates per sat_i.
//
//   Optional build macro: INTEGRATE_DUMP_ROUND_SHIFT_EN
//     defined   -> data_o = sat((total + 2^(SHIFT-1)) >>> SHIFT), no added latency
//     undefined -> data_o = raw window total, SHIFT ignored
//
// Ports
//   clk_i       rising-edge clock
//   rst_n_i     asynchronous active-low reset
//   en_i        enable; low flushes the window and any pending output
//   dump_len_i  samples per window (0 behaves as 1), latched at window start
//   sat_i       1 = saturating accumulate, 0 = wrap
//   data_i      signed input sample
//   valid_i     input sample valid
//   ready_o     input can accept a sample (combinational from ready_i)
//   data_o      signed window result
//   sat_o       saturation occurred in the window of data_o
//   valid_o     output valid
//   ready_i     downstream accepts output
module integrate_dump_accumulator #(
  parameter int I_BW   = 5,
  parameter int O_BW   = 12,
  parameter int CNT_BW = 8,
  parameter int SHIFT  = 0
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              en_i,
  input  logic [CNT_BW-1:0] dump_len_i,
  input  logic              sat_i,
  input  logic [I_BW-1:0]   data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic [O_BW-1:0]   data_o,
  output logic              sat_o,
  output logic              valid_o,
  input  logic              ready_i
);

  localparam logic [O_BW-1:0] MAX_VAL = {1'b0, {(O_BW-1){1'b1}}};
  localparam logic [O_BW-1:0] MIN_VAL = {1'b1, {(O_BW-1){1'b0}}};

  logic [O_BW-1:0]   acc;
  logic [CNT_BW-1:0] cnt;
  logic [CNT_BW-1:0] len_q;
  logic              win_sat;

  logic [CNT_BW-1:0] len_eff;
  logic              last;
  logic              accept;
  logic [O_BW:0]     sum;
  logic              ovf;
  logic              ovf_sat;
  logic [O_BW-1:0]   acc_nxt;
  logic [O_BW-1:0]   out_val;

  // At window start the live dump_len_i is used so the first sample already
  // sees the new length; afterwards the latched copy rules the window.
  assign len_eff = (cnt == '0) ? ((dump_len_i == '0) ? CNT_BW'(1) : dump_len_i)
                               : len_q;
  assign last    = (cnt == len_eff - CNT_BW'(1));

  // Only the closing sample needs the output register, so stall just that one.
  assign ready_o = en_i & ~(valid_o & ~ready_i & last);
  assign accept  = valid_i & ready_o;

  assign sum     = {acc[O_BW-1], acc} + {{(O_BW+1-I_BW){data_i[I_BW-1]}}, data_i};
  assign ovf     = sum[O_BW] ^ sum[O_BW-1];
  assign ovf_sat = sat_i & ovf;

  always_comb begin
    acc_nxt = sum[O_BW-1:0];
    if (ovf_sat) acc_nxt = sum[O_BW] ? MIN_VAL : MAX_VAL;
  end

`ifdef INTEGRATE_DUMP_ROUND_SHIFT_EN
  // Round half up on the window total (post wrap/saturate), one guard bit
  // so the rounding add cannot overflow before the shift.
  localparam int            RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [O_BW:0] RND     = (SHIFT > 0) ? ((O_BW+1)'(1) << RND_POS) : '0;

  logic signed [O_BW:0] rnd_sum;
  logic signed [O_BW:0] shifted;

  assign rnd_sum = $signed({acc_nxt[O_BW-1], acc_nxt} + RND);
  assign shifted = rnd_sum >>> SHIFT;

  always_comb begin
    out_val = shifted[O_BW-1:0];
    if (shifted[O_BW] ^ shifted[O_BW-1]) out_val = shifted[O_BW] ? MIN_VAL : MAX_VAL;
  end
`else
  assign out_val = acc_nxt;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acc     <= '0;
      cnt     <= '0;
      len_q   <= '0;
      win_sat <= 1'b0;
      data_o  <= '0;
      sat_o   <= 1'b0;
      valid_o <= 1'b0;
    end else if (!en_i) begin
      // Synchronous flush: window and pending output are dropped.
      acc     <= '0;
      cnt     <= '0;
      win_sat <= 1'b0;
      valid_o <= 1'b0;
    end else begin
      if (accept) begin
        if (cnt == '0) len_q <= len_eff;
        if (last) begin
          acc     <= '0;
          cnt     <= '0;
          win_sat <= 1'b0;
          data_o  <= out_val;
          sat_o   <= win_sat | ovf_sat;
          valid_o <= 1'b1;
        end else begin
          acc     <= acc_nxt;
          cnt     <= cnt + CNT_BW'(1);
          win_sat <= win_sat | ovf_sat;
        end
      end
      // A transfer without a same-cycle completion empties the register.
      if (!(accept && last) && valid_o && ready_i) valid_o <= 1'b0;
    end
  end

endmodule
